// File: rtl/prism_shift_fifo.sv
// Serial shift engine with a word FIFO; all state updates on the clk edge, status is combinational from registers.
// No handshake backpressure: a push when full or a pop when empty is dropped and raises a sticky flag.

module prism_fifo #(
  parameter int W = 8,
  parameter int D = 4,
  localparam int AW = $clog2(D),
  localparam int LW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [LW-1:0] count
);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // push/pop arrive already qualified against full/empty by the caller
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = (count == '0) ? '0 : mem[rd_ptr];

endmodule

module prism_shift_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(WIDTH + 1),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             shift,
  input  logic             load,
  input  logic             mode,
  input  logic             dir,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             shift_done,
  input  logic             cpu_wr,
  input  logic [WIDTH-1:0] cpu_wdata,
  input  logic             cpu_rd,
  output logic [WIDTH-1:0] rd_data,
  input  logic [LW-1:0]    thresh,
  input  logic             flush,
  input  logic             clr_flags,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             irq
);

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bit_cnt;
  logic [LW-1:0]    count;

  logic ld_go, sh_go, rx_load, tx_load;
  logic push_req, pop_req, push_ok, pop_ok;
  logic ovf_set, unf_set, lvl_hit;
  logic [WIDTH-1:0] push_dat;

  assign ld_go   = enable & load;
  assign sh_go   = enable & shift & ~load;
  assign rx_load = ld_go & ~mode;
  assign tx_load = ld_go & mode;

  // The mode selects which side owns each FIFO port, so requests never collide
  assign push_req = rx_load | (cpu_wr & mode);
  assign pop_req  = tx_load | (cpu_rd & ~mode);
  assign push_dat = mode ? cpu_wdata : sreg;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign pop_ok  = pop_req & ~empty;
  assign push_ok = push_req & (~full | pop_ok);
  assign ovf_set = push_req & ~push_ok;
  assign unf_set = pop_req & empty;

  prism_fifo #(.W(WIDTH), .D(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push_ok),
    .pop   (pop_ok),
    .wdata (push_dat),
    .rdata (rd_data),
    .count (count)
  );

  // rd_data is already zero when empty, which gives the underflow load value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (flush) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (tx_load) begin
      sreg    <= rd_data;
      bit_cnt <= '0;
    end else if (rx_load) begin
      bit_cnt <= '0;
    end else if (sh_go) begin
      sreg <= dir ? {ser_in, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], ser_in};
      if (bit_cnt != CW'(WIDTH)) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= overflow;
      underflow <= underflow;
    end else if (clr_flags) begin
      overflow  <= ovf_set;
      underflow <= unf_set;
    end else begin
      overflow  <= overflow | ovf_set;
      underflow <= underflow | unf_set;
    end
  end

  assign lvl_hit    = mode ? (count < thresh) : (count >= thresh);
  assign irq        = overflow | underflow | ((thresh != '0) & lvl_hit);
  assign level      = count;
  assign ser_out    = dir ? sreg[0] : sreg[WIDTH-1];
  assign shift_done = (bit_cnt == CW'(WIDTH));

endmodule

// File: tb/tb_prism_shift_fifo.sv
// Directed bench for prism_shift_fifo (WIDTH=8, DEPTH=4): vector table for RX paths,
// hand sequences for TX, wrap, simultaneous push/pop and asynchronous reset.
module tb_prism_shift_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, shift, load, mode, dir, ser_in;
  logic       ser_out, shift_done;
  logic       cpu_wr, cpu_rd;
  logic [7:0] cpu_wdata, rd_data;
  logic [2:0] thresh, level;
  logic       flush, clr_flags;
  logic       empty, full, overflow, underflow, irq;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prism_shift_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .shift(shift), .load(load),
    .mode(mode), .dir(dir), .ser_in(ser_in), .ser_out(ser_out),
    .shift_done(shift_done), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rd(cpu_rd), .rd_data(rd_data), .thresh(thresh), .flush(flush),
    .clr_flags(clr_flags), .level(level), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow), .irq(irq)
  );

  // {ser_out, shift_done, rd_data, level, empty, full, overflow, underflow, irq}
  logic [17:0] outs;
  assign outs = {ser_out, shift_done, rd_data, level, empty, full, overflow, underflow, irq};

  // control word: {enable, shift, load, mode, dir, ser_in, cpu_wr, cpu_rd, flush, clr_flags}
  typedef struct {
    logic [9:0]  c;
    logic [7:0]  wd;
    logic [2:0]  th;
    logic [17:0] e;
  } vec_t;

  localparam logic [9:0] SH1 = 10'b1_1_0_0_0_1_0_0_0_0;
  localparam logic [9:0] SH0 = 10'b1_1_0_0_0_0_0_0_0_0;
  localparam logic [9:0] LD  = 10'b1_0_1_0_0_0_0_0_0_0;
  localparam logic [9:0] RD  = 10'b0_0_0_0_0_0_0_1_0_0;
  localparam logic [9:0] FL  = 10'b0_0_0_0_0_0_0_0_1_0;
  localparam logic [9:0] CF  = 10'b0_0_0_0_0_0_0_0_0_1;
  localparam logic [17:0] RST_OUT = {1'b0, 1'b0, 8'h00, 3'd0, 5'b10000};

  vec_t tv[$];
  logic [7:0] wv[11];
  logic       tx_bits[8];

  function automatic vec_t v(input logic [9:0] c, input logic [7:0] wd,
                             input logic [2:0] th, input logic [17:0] e);
    vec_t r;
    r.c = c; r.wd = wd; r.th = th; r.e = e;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable = 1'b1; shift = 1'b0; load = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    flush = 1'b0; clr_flags = 1'b0; ser_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; idle(); enable = 1'b0; mode = 1'b0; dir = 1'b0;
    cpu_wdata = 8'h00; thresh = 3'd0;
    #12;
    chk("reset_hold", outs, RST_OUT);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc();
    chk("reset_state", outs, RST_OUT);

    // RX basic: 1,0,1,0,0,1,0,1 MSB-first -> 0xA5
    tv.push_back(v(SH1, 8'h00, 3'd0, {2'b00, 8'h00, 3'd0, 5'b10000}));
    tv.push_back(v(SH0, 8'h00, 3'd0, {2'b00, 8'h00, 3'd0, 5'b10000}));
    tv.push_back(v(SH1, 8'h00, 3'd0, {2'b00, 8'h00, 3'd0, 5'b10000}));
    tv.push_back(v(SH0, 8'h00, 3'd0, {2'b00, 8'h00, 3'd0, 5'b10000}));
    tv.push_back(v(SH0, 8'h00, 3'd0, {2'b00, 8'h00, 3'd0, 5'b10000}));
    tv.push_back(v(SH1, 8'h00, 3'd0, {2'b00, 8'h00, 3'd0, 5'b10000}));
    tv.push_back(v(SH0, 8'h00, 3'd0, {2'b00, 8'h00, 3'd0, 5'b10000}));
    tv.push_back(v(SH1, 8'h00, 3'd0, {2'b11, 8'h00, 3'd0, 5'b10000}));
    tv.push_back(v(LD,  8'h00, 3'd0, {2'b10, 8'hA5, 3'd1, 5'b00000}));
    tv.push_back(v(RD,  8'h00, 3'd0, {2'b10, 8'h00, 3'd0, 5'b10000}));
    // Full boundary, load+pop while full, overflow, clr vs new error, flush keeps flags
    tv.push_back(v(LD,  8'h00, 3'd0, {2'b10, 8'hA5, 3'd1, 5'b00000}));
    tv.push_back(v(LD,  8'h00, 3'd0, {2'b10, 8'hA5, 3'd2, 5'b00000}));
    tv.push_back(v(LD,  8'h00, 3'd0, {2'b10, 8'hA5, 3'd3, 5'b00000}));
    tv.push_back(v(LD,  8'h00, 3'd0, {2'b10, 8'hA5, 3'd4, 5'b01000}));
    tv.push_back(v(LD | RD, 8'h00, 3'd0, {2'b10, 8'hA5, 3'd4, 5'b01000}));
    tv.push_back(v(LD,  8'h00, 3'd0, {2'b10, 8'hA5, 3'd4, 5'b01101}));
    tv.push_back(v(LD | CF, 8'h00, 3'd0, {2'b10, 8'hA5, 3'd4, 5'b01101}));
    tv.push_back(v(FL,  8'h00, 3'd0, {2'b00, 8'h00, 3'd0, 5'b10101}));
    tv.push_back(v(CF,  8'h00, 3'd0, {2'b00, 8'h00, 3'd0, 5'b10000}));
    // Threshold 2 in RX
    tv.push_back(v(SH1, 8'h00, 3'd2, {2'b00, 8'h00, 3'd0, 5'b10000}));
    tv.push_back(v(LD,  8'h00, 3'd2, {2'b00, 8'h01, 3'd1, 5'b00000}));
    tv.push_back(v(LD,  8'h00, 3'd2, {2'b00, 8'h01, 3'd2, 5'b00001}));
    tv.push_back(v(FL,  8'h00, 3'd2, {2'b00, 8'h00, 3'd0, 5'b10000}));
    // Gating and load-over-shift priority: build 0x60, then shift+load must push 0x60
    tv.push_back(v(SH1, 8'h00, 3'd0, {2'b00, 8'h00, 3'd0, 5'b10000}));
    tv.push_back(v(SH1, 8'h00, 3'd0, {2'b00, 8'h00, 3'd0, 5'b10000}));
    for (int k = 0; k < 5; k++)
      tv.push_back(v(SH0, 8'h00, 3'd0, {2'b00, 8'h00, 3'd0, 5'b10000}));
    tv.push_back(v(10'b0_1_0_0_0_1_0_0_0_0, 8'h00, 3'd0, {2'b00, 8'h00, 3'd0, 5'b10000}));
    tv.push_back(v(10'b0_0_1_0_0_0_0_0_0_0, 8'h00, 3'd0, {2'b00, 8'h00, 3'd0, 5'b10000}));
    tv.push_back(v(10'b1_1_1_0_0_1_0_0_0_0, 8'h00, 3'd0, {2'b00, 8'h60, 3'd1, 5'b00000}));
    tv.push_back(v(SH1, 8'h00, 3'd0, {2'b10, 8'h60, 3'd1, 5'b00000}));
    // Wrong-mode push ignored, RX pop-when-empty underflow
    tv.push_back(v(10'b0_0_0_0_0_0_1_0_0_0, 8'hFF, 3'd0, {2'b10, 8'h60, 3'd1, 5'b00000}));
    tv.push_back(v(RD,  8'h00, 3'd0, {2'b10, 8'h00, 3'd0, 5'b10000}));
    tv.push_back(v(RD,  8'h00, 3'd0, {2'b10, 8'h00, 3'd0, 5'b10011}));
    tv.push_back(v(CF,  8'h00, 3'd0, {2'b10, 8'h00, 3'd0, 5'b10000}));

    foreach (tv[i]) begin
      {enable, shift, load, mode, dir, ser_in, cpu_wr, cpu_rd, flush, clr_flags} = tv[i].c;
      cpu_wdata = tv[i].wd;
      thresh    = tv[i].th;
      cyc();
      chk($sformatf("vec%0d", i), outs, tv[i].e);
    end
    idle(); thresh = 3'd0;

    // TX: flush on mode change, underflow load zeroes sreg
    mode = 1'b1; dir = 1'b1; flush = 1'b1; cyc(); flush = 1'b0;
    chk("tx_flush", {level, empty}, {3'd0, 1'b1});
    shift = 1'b1; ser_in = 1'b1; repeat (8) cyc(); shift = 1'b0; ser_in = 1'b0;
    chk("tx_fill_ones", {ser_out, shift_done}, 2'b11);
    load = 1'b1; cyc(); load = 1'b0;
    chk("tx_underflow", {ser_out, shift_done, underflow, irq}, 4'b0011);
    clr_flags = 1'b1; cyc(); clr_flags = 1'b0;
    chk("tx_clr_flags", {underflow, irq}, 2'b00);
    cpu_rd = 1'b1; cyc(); cpu_rd = 1'b0;
    chk("tx_wrong_mode_rd", {underflow, level}, {1'b0, 3'd0});

    // TX LSB-first of 0x3C
    cpu_wr = 1'b1; cpu_wdata = 8'h3C; cyc(); cpu_wr = 1'b0;
    chk("tx_push", {rd_data, level}, {8'h3C, 3'd1});
    load = 1'b1; cyc(); load = 1'b0;
    chk("tx_load", {level, empty}, {3'd0, 1'b1});
    tx_bits = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tx_bit%0d", i), ser_out, tx_bits[i]);
      shift = 1'b1; cyc(); shift = 1'b0;
    end
    chk("tx_done", {shift_done, ser_out}, 2'b10);

    // TX full: push overflow, then push alongside a TX load succeeds
    for (int k = 1; k <= 4; k++) begin
      cpu_wr = 1'b1; cpu_wdata = 8'(k); cyc();
    end
    cpu_wr = 1'b0;
    chk("tx_full", {full, level, overflow}, {1'b1, 3'd4, 1'b0});
    cpu_wr = 1'b1; cpu_wdata = 8'h05; cyc(); cpu_wr = 1'b0;
    chk("tx_overflow", {overflow, level, irq}, {1'b1, 3'd4, 1'b1});
    clr_flags = 1'b1; cyc(); clr_flags = 1'b0;
    cpu_wr = 1'b1; cpu_wdata = 8'h06; load = 1'b1; cyc(); cpu_wr = 1'b0; load = 1'b0;
    chk("tx_push_pop_full", {overflow, level, rd_data, ser_out}, {1'b0, 3'd4, 8'h02, 1'b1});

    // TX threshold: irq while level < thresh
    thresh = 3'd3; cyc();
    chk("tx_thr_lv4", irq, 1'b0);
    load = 1'b1; cyc(); load = 1'b0;
    chk("tx_thr_lv3", {level, irq}, {3'd3, 1'b0});
    load = 1'b1; cyc(); load = 1'b0;
    chk("tx_thr_lv2", {level, irq}, {3'd2, 1'b1});
    thresh = 3'd0; flush = 1'b1; cyc(); flush = 1'b0;

    // Pointer wrap: 10 simultaneous push/pop pairs with one word standing
    for (int i = 0; i < 11; i++) wv[i] = 8'(i * 37 + 5);
    cpu_wr = 1'b1; cpu_wdata = wv[0]; cyc();
    for (int i = 0; i < 10; i++) begin
      cpu_wdata = wv[i + 1]; load = 1'b1; cyc();
      chk($sformatf("wrap%0d", i), {rd_data, level, ser_out}, {wv[i + 1], 3'd1, wv[i][0]});
    end
    cpu_wr = 1'b0; load = 1'b0;

    // Push and pop together while empty: push lands, pop counts as underflow
    flush = 1'b1; cyc(); flush = 1'b0;
    cpu_wr = 1'b1; cpu_wdata = 8'h77; load = 1'b1; cyc(); cpu_wr = 1'b0; load = 1'b0;
    chk("empty_push_pop", {rd_data, level, underflow, ser_out}, {8'h77, 3'd1, 1'b1, 1'b0});

    // Asynchronous reset mid-word
    shift = 1'b1; ser_in = 1'b1; repeat (3) cyc(); shift = 1'b0;
    rst_n = 1'b0; #2;
    chk("reset_mid_word", outs, RST_OUT);
    cyc(); rst_n = 1'b1; cyc();
    chk("after_reset", outs, RST_OUT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
